// File: rtl/conversor_bin_bcd_peso_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD weight converter.
package conversor_bin_bcd_peso_pkg;

    localparam int BIN_W   = 14;
    localparam int DIGITS  = 4;
    localparam int MAX_VAL = 9999;
    localparam int BCD_W   = 4 * DIGITS;
    localparam int CNT_W   = $clog2(BIN_W);

    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/conversor_bin_bcd_peso_if.sv
// Request/result bundle between the weight source and the converter.
interface conversor_bin_bcd_peso_if;
    import conversor_bin_bcd_peso_pkg::*;

    logic [BIN_W-1:0] peso_bin;
    logic             start;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] BCD_total;
    logic             sobrecarga;

    modport master (
        output peso_bin, start,
        input  busy, done, BCD_total, sobrecarga
    );

    modport slave (
        input  peso_bin, start,
        output busy, done, BCD_total, sobrecarga
    );

endinterface

// File: rtl/conversor_bin_bcd_peso_ajuste_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module ajuste_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Correction stays inside the nibble; inputs are always 0..9 here
    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/conversor_bin_bcd_peso.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Inputs above MAX_VAL saturate to 9999 and raise sobrecarga.
module conversor_bin_bcd_peso
    import conversor_bin_bcd_peso_pkg::*;
(
    input logic                      clk,
    input logic                      rst_n,
    conversor_bin_bcd_peso_if.slave  bus
);

    state_t             state_q;
    logic [BIN_W-1:0]   bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_total_q;
    logic               sobrecarga_q;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_d;
    logic [BIN_W-1:0]       bin_d;
    logic [BCD_W+BIN_W-1:0] shift_cat;

    // Per-digit add-3 correction ahead of the shift
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            ajuste_add3 u_adj (
                .din  (bcd_q[4*g +: 4]),
                .dout (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    // Next value of the {bcd, bin} pair for one SHIFT step
    always_comb begin
        shift_cat = {bcd_adj, bin_q} << 1;
        bcd_d     = shift_cat[BCD_W+BIN_W-1:BIN_W];
        bin_d     = shift_cat[BIN_W-1:0];
    end

    // Control FSM with registered busy/done/result; the done cycle is spent
    // back in IDLE so the next start can be taken right after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bcd_total_q  <= '0;
            sobrecarga_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        bin_q   <= (bus.peso_bin > MAX_BIN) ? MAX_BIN : bus.peso_bin;
                        ovf_q   <= (bus.peso_bin > MAX_BIN);
                        bcd_q   <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcd_q   <= bcd_d;
                    bin_q   <= bin_d;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == CNT_LAST) state_q <= DONE;
                end
                DONE: begin
                    bcd_total_q  <= bcd_q;
                    sobrecarga_q <= ovf_q;
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.BCD_total  = bcd_total_q;
    assign bus.sobrecarga = sobrecarga_q;

endmodule

// File: tb/tb_conversor_bin_bcd_peso.sv
// Directed + randomized bench for the binary-to-BCD weight converter.
module tb_conversor_bin_bcd_peso;
    import conversor_bin_bcd_peso_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    conversor_bin_bcd_peso_if bus ();

    conversor_bin_bcd_peso dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of the saturated value
    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic digits_ok(input logic [15:0] b);
        return (b[15:12] <= 4'd9) && (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count rising edges (sampled 1 time unit after) until done, bounded
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.done && n < 40);
    endtask

    task automatic check_result(input string tag, input int v);
        chk({tag, " bcd"}, 32'(bus.BCD_total), 32'(ref_bcd(v)));
        chk({tag, " ovf"}, 32'(bus.sobrecarga), 32'(v > 9999));
        chk({tag, " digits"}, 32'(digits_ok(bus.BCD_total)), 32'd1);
    endtask

    // One isolated conversion: start pulse, latency, result, single-cycle done
    task automatic do_conv(input int v, input string tag);
        int n;
        @(negedge clk);
        bus.peso_bin = 14'(v);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        wait_done(n);
        chk({tag, " latency"}, 32'(n), 32'd15);
        check_result(tag, v);
        @(posedge clk); #1;
        chk({tag, " done pulse"}, 32'(bus.done), 32'd0);
        chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        int v;
        int dones;
        logic [15:0] held;
        tests        = 0;
        fails        = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.peso_bin = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst bcd", 32'(bus.BCD_total), 32'd0);
        chk("rst ovf", 32'(bus.sobrecarga), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic conversion and downstream split
        do_conv(1234, "1234");
        chk("split int", 32'(bus.BCD_total[15:12]), 32'h1);
        chk("split frac", 32'(bus.BCD_total[11:0]), 32'h234);

        // Back-to-back 0 then 9999 with start held across the done cycle
        @(negedge clk);
        bus.peso_bin = 14'd0;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        wait_done(n);
        chk("b2b first lat", 32'(n), 32'd15);
        check_result("b2b 0", 0);
        bus.peso_bin = 14'd9999;
        wait_done(n);
        bus.start = 1'b0;
        chk("b2b spacing", 32'(n), 32'd16);
        check_result("b2b 9999", 9999);
        @(posedge clk); #1;

        // Saturation then a normal value
        do_conv(12000, "sat");
        do_conv(500, "500");

        // Start held high, input changed mid-conversion; count dones
        @(negedge clk);
        bus.peso_bin = 14'd507;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        bus.peso_bin = 14'd999;
        dones = 0;
        held  = '0;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                held = bus.BCD_total;
            end
        end
        chk("held first dones", 32'(dones), 32'd1);
        chk("held first bcd", 32'(held), 32'h0507);
        dones = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                held = bus.BCD_total;
            end
        end
        bus.start = 1'b0;
        chk("held period dones", 32'(dones), 32'd1);
        chk("held second bcd", 32'(held), 32'h0999);
        repeat (20) @(posedge clk);
        #1;
        chk("held drained busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of a conversion
        @(negedge clk);
        bus.peso_bin = 14'd4321;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort bcd", 32'(bus.BCD_total), 32'd0);
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("abort no done", 32'(dones), 32'd0);
        do_conv(4321, "4321");

        // Boundary values
        do_conv(9, "9");
        do_conv(10, "10");
        do_conv(999, "999");
        do_conv(1000, "1000");
        do_conv(9998, "9998");
        do_conv(10000, "10000");
        do_conv(16383, "16383");

        // Random sweep across the full input range
        for (int i = 0; i < 150; i++) begin
            v = int'($urandom_range(16383, 0));
            do_conv(v, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
